// File: rtl/ysyx_22050078_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050078_wb_scoreboard
// Brief    : Write-back merge of LSU results and MDU completions onto one
//            registered regfile port, plus the MDU pending-register bitmap.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050078_wb_scoreboard #(
    parameter int CPU_WIDTH = 64,
    parameter int REG_ADDRW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_ls_valid,
    input  logic                 i_ls_rdwen,
    input  logic [REG_ADDRW-1:0] i_ls_rd_addr,
    input  logic [CPU_WIDTH-1:0] i_ls_rd_data,
    input  logic                 i_mdu_valid,
    output logic                 o_mdu_ready,
    input  logic [REG_ADDRW-1:0] i_mdu_rd_addr,
    input  logic [CPU_WIDTH-1:0] i_mdu_rd_data,
    input  logic                 i_iss_long,
    input  logic [REG_ADDRW-1:0] i_iss_rd_addr,
    input  logic [REG_ADDRW-1:0] i_idu_rs1_addr,
    input  logic [REG_ADDRW-1:0] i_idu_rs2_addr,
    input  logic [REG_ADDRW-1:0] i_idu_rd_addr,
    output logic                 o_rs1_pending,
    output logic                 o_rs2_pending,
    output logic                 o_rd_pending,
    output logic                 o_wbu_rdwen,
    output logic [REG_ADDRW-1:0] o_wbu_rd_addr,
    output logic [CPU_WIDTH-1:0] o_wbu_rd_data
);

    localparam int NREG = 2 ** REG_ADDRW;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LSU  = 2'd1,
        SRC_HOLD = 2'd2,
        SRC_MDU  = 2'd3
    } src_e;

    logic [NREG-1:0]      r_pending;
    logic                 r_hold_valid;
    logic [REG_ADDRW-1:0] r_hold_addr;
    logic [CPU_WIDTH-1:0] r_hold_data;
    logic                 r_wbu_rdwen;
    logic [REG_ADDRW-1:0] r_wbu_addr;
    logic [CPU_WIDTH-1:0] r_wbu_data;

    src_e                 w_src;
    logic                 w_ls_wr;
    logic                 w_mdu_acc;
    logic                 w_hold_load;
    logic [REG_ADDRW-1:0] w_wr_addr;
    logic [CPU_WIDTH-1:0] w_wr_data;
    logic [NREG-1:0]      w_set_vec;
    logic [NREG-1:0]      w_clr_vec;
    logic [NREG-1:0]      w_pending_nxt;

    assign w_ls_wr   = i_ls_valid && i_ls_rdwen;
    assign w_mdu_acc = i_mdu_valid && !r_hold_valid;

    // LSU cannot stall, so it always owns the port; a parked MDU result goes next.
    always_comb begin
        w_src       = SRC_NONE;
        w_wr_addr   = i_ls_rd_addr;
        w_wr_data   = i_ls_rd_data;
        w_hold_load = 1'b0;
        if (w_ls_wr) begin
            w_src       = SRC_LSU;
            w_hold_load = w_mdu_acc;
        end else if (r_hold_valid) begin
            w_src     = SRC_HOLD;
            w_wr_addr = r_hold_addr;
            w_wr_data = r_hold_data;
        end else if (w_mdu_acc) begin
            w_src     = SRC_MDU;
            w_wr_addr = i_mdu_rd_addr;
            w_wr_data = i_mdu_rd_data;
        end
    end

    // Set is OR-ed in after the clear so a same-edge reissue keeps the bit.
    always_comb begin
        w_set_vec = '0;
        w_clr_vec = '0;
        if (i_iss_long && (i_iss_rd_addr != '0)) begin
            w_set_vec = {{(NREG-1){1'b0}}, 1'b1} << i_iss_rd_addr;
        end
        if ((w_src == SRC_HOLD) || (w_src == SRC_MDU)) begin
            w_clr_vec = {{(NREG-1){1'b0}}, 1'b1} << w_wr_addr;
        end
        w_pending_nxt = (r_pending & ~w_clr_vec) | w_set_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending    <= '0;
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
            r_wbu_rdwen  <= 1'b0;
            r_wbu_addr   <= '0;
            r_wbu_data   <= '0;
        end else begin
            r_pending <= w_pending_nxt;

            if (w_src != SRC_NONE) begin
                r_wbu_rdwen <= (w_wr_addr != '0);
                r_wbu_addr  <= w_wr_addr;
                r_wbu_data  <= w_wr_data;
            end else begin
                r_wbu_rdwen <= 1'b0;
            end

            if (w_hold_load) begin
                r_hold_valid <= 1'b1;
                r_hold_addr  <= i_mdu_rd_addr;
                r_hold_data  <= i_mdu_rd_data;
            end else if (w_src == SRC_HOLD) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    assign o_mdu_ready   = !r_hold_valid;
    assign o_wbu_rdwen   = r_wbu_rdwen;
    assign o_wbu_rd_addr = r_wbu_addr;
    assign o_wbu_rd_data = r_wbu_data;

    assign o_rs1_pending = (i_idu_rs1_addr != '0) && r_pending[i_idu_rs1_addr];
    assign o_rs2_pending = (i_idu_rs2_addr != '0) && r_pending[i_idu_rs2_addr];
    assign o_rd_pending  = (i_idu_rd_addr  != '0) && r_pending[i_idu_rd_addr];

    // An LSU write to a register with an MDU result still in flight breaks the IDU contract.
    a_no_ls_to_pending : assert property (@(posedge clk) disable iff (!rst_n)
        (w_ls_wr && (i_ls_rd_addr != '0)) |-> !r_pending[i_ls_rd_addr]);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050078_wb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050078_wb_scoreboard
// Brief    : Directed self-checking bench for the write-back scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050078_wb_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        ls_valid, ls_rdwen, mdu_valid, iss_long;
    logic [4:0]  ls_addr, mdu_addr, iss_addr, rs1, rs2, rd;
    logic [63:0] ls_data, mdu_data;
    logic        mdu_ready, rs1_p, rs2_p, rd_p, wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;

    int n_assert = 0;
    int n_fail   = 0;

    ysyx_22050078_wb_scoreboard #(.CPU_WIDTH(64), .REG_ADDRW(5)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ls_valid     (ls_valid),
        .i_ls_rdwen     (ls_rdwen),
        .i_ls_rd_addr   (ls_addr),
        .i_ls_rd_data   (ls_data),
        .i_mdu_valid    (mdu_valid),
        .o_mdu_ready    (mdu_ready),
        .i_mdu_rd_addr  (mdu_addr),
        .i_mdu_rd_data  (mdu_data),
        .i_iss_long     (iss_long),
        .i_iss_rd_addr  (iss_addr),
        .i_idu_rs1_addr (rs1),
        .i_idu_rs2_addr (rs2),
        .i_idu_rd_addr  (rd),
        .o_rs1_pending  (rs1_p),
        .o_rs2_pending  (rs2_p),
        .o_rd_pending   (rd_p),
        .o_wbu_rdwen    (wb_en),
        .o_wbu_rd_addr  (wb_addr),
        .o_wbu_rd_data  (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ls_valid = 1'b0; ls_rdwen = 1'b0; ls_addr = '0; ls_data = '0;
        mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
        iss_long = 1'b0; iss_addr = '0;
    endtask

    task automatic ls(input logic [4:0] a, input logic [63:0] d);
        ls_valid = 1'b1; ls_rdwen = 1'b1; ls_addr = a; ls_data = d;
    endtask

    task automatic mdu(input logic [4:0] a, input logic [63:0] d);
        mdu_valid = 1'b1; mdu_addr = a; mdu_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_long = 1'b1; iss_addr = a;
    endtask

    initial begin
        rst_n = 1'b0;
        rs1 = '0; rs2 = '0; rd = '0;
        idle();
        tick();
        tick();
        chk("rst_rdwen", 64'(wb_en), 64'd0);
        chk("rst_addr",  64'(wb_addr), 64'd0);
        chk("rst_data",  wb_data, 64'd0);
        chk("rst_ready", 64'(mdu_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Plain LSU write, visible for exactly one cycle.
        ls(5'd5, 64'h1234);
        tick();
        idle();
        chk("t1_rdwen", 64'(wb_en), 64'd1);
        chk("t1_addr",  64'(wb_addr), 64'd5);
        chk("t1_data",  wb_data, 64'h1234);
        tick();
        chk("t1_rdwen_off", 64'(wb_en), 64'd0);
        chk("t1_data_hold", wb_data, 64'h1234);

        // Issue to x7: not visible until registered, then cleared by MDU write.
        iss(5'd7); rs1 = 5'd7; rd = 5'd7;
        #1;
        chk("t2_no_bypass", 64'(rs1_p), 64'd0);
        tick();
        idle();
        chk("t2_rs1_pend", 64'(rs1_p), 64'd1);
        chk("t2_rd_pend",  64'(rd_p), 64'd1);
        chk("t2_rs2_x0",   64'(rs2_p), 64'd0);
        mdu(5'd7, 64'hAB);
        tick();
        idle();
        chk("t2_rdwen", 64'(wb_en), 64'd1);
        chk("t2_addr",  64'(wb_addr), 64'd7);
        chk("t2_data",  wb_data, 64'hAB);
        chk("t2_rs1_clr", 64'(rs1_p), 64'd0);
        chk("t2_ready", 64'(mdu_ready), 64'd1);
        tick();
        chk("t2_rdwen_off", 64'(wb_en), 64'd0);

        // Single-cycle collision: MDU result parked for one cycle.
        iss(5'd9); rs2 = 5'd9;
        tick();
        idle();
        ls(5'd3, 64'h11); mdu(5'd9, 64'h22);
        tick();
        idle();
        chk("t3a_addr",  64'(wb_addr), 64'd3);
        chk("t3a_data",  wb_data, 64'h11);
        chk("t3a_ready", 64'(mdu_ready), 64'd0);
        chk("t3a_pend",  64'(rs2_p), 64'd1);
        tick();
        chk("t3a_rdwen2", 64'(wb_en), 64'd1);
        chk("t3a_addr2",  64'(wb_addr), 64'd9);
        chk("t3a_data2",  wb_data, 64'h22);
        chk("t3a_ready2", 64'(mdu_ready), 64'd1);
        chk("t3a_pclr",   64'(rs2_p), 64'd0);

        // LSU burst of three holds the parked result until cycle+4.
        iss(5'd9);
        tick();
        idle();
        ls(5'd3, 64'h33); mdu(5'd9, 64'h44);
        tick();
        idle();
        chk("t3b_c1_addr",  64'(wb_addr), 64'd3);
        chk("t3b_c1_ready", 64'(mdu_ready), 64'd0);
        ls(5'd4, 64'h55);
        tick();
        idle();
        chk("t3b_c2_data",  wb_data, 64'h55);
        chk("t3b_c2_ready", 64'(mdu_ready), 64'd0);
        chk("t3b_c2_pend",  64'(rs2_p), 64'd1);
        ls(5'd6, 64'h66);
        tick();
        idle();
        chk("t3b_c3_addr", 64'(wb_addr), 64'd6);
        chk("t3b_c3_data", wb_data, 64'h66);
        tick();
        chk("t3b_c4_rdwen", 64'(wb_en), 64'd1);
        chk("t3b_c4_addr",  64'(wb_addr), 64'd9);
        chk("t3b_c4_data",  wb_data, 64'h44);
        chk("t3b_c4_ready", 64'(mdu_ready), 64'd1);
        chk("t3b_c4_pclr",  64'(rs2_p), 64'd0);

        // x0 is never pending and never written.
        iss(5'd0); ls(5'd0, 64'hFF); rd = 5'd0;
        tick();
        idle();
        chk("t4_rdwen", 64'(wb_en), 64'd0);
        chk("t4_pend",  64'(rd_p), 64'd0);
        tick();
        chk("t4_rdwen2", 64'(wb_en), 64'd0);

        // Clear and set of x4 on the same edge: set wins.
        iss(5'd4); rd = 5'd4;
        tick();
        idle();
        chk("t5_pend_pre", 64'(rd_p), 64'd1);
        mdu(5'd4, 64'h77); iss(5'd4);
        tick();
        idle();
        chk("t5_rdwen", 64'(wb_en), 64'd1);
        chk("t5_data",  wb_data, 64'h77);
        chk("t5_pend",  64'(rd_p), 64'd1);
        mdu(5'd4, 64'h78);
        tick();
        idle();
        chk("t5_pclr", 64'(rd_p), 64'd0);

        // Reset with a parked result and three pending registers.
        iss(5'd10); tick(); idle();
        iss(5'd11); tick(); idle();
        iss(5'd12); tick(); idle();
        ls(5'd1, 64'h1); mdu(5'd10, 64'hAA);
        tick();
        idle();
        rs1 = 5'd10; rs2 = 5'd11; rd = 5'd12;
        #1;
        chk("t6_ready_pre", 64'(mdu_ready), 64'd0);
        chk("t6_p10_pre",   64'(rs1_p), 64'd1);
        chk("t6_p11_pre",   64'(rs2_p), 64'd1);
        chk("t6_p12_pre",   64'(rd_p), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_rdwen", 64'(wb_en), 64'd0);
        chk("t6_addr",  64'(wb_addr), 64'd0);
        chk("t6_data",  wb_data, 64'd0);
        chk("t6_ready", 64'(mdu_ready), 64'd1);
        chk("t6_p10",   64'(rs1_p), 64'd0);
        chk("t6_p11",   64'(rs2_p), 64'd0);
        chk("t6_p12",   64'(rd_p), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("t6_post_rdwen", 64'(wb_en), 64'd0);
        tick();
        chk("t6_post_rdwen2", 64'(wb_en), 64'd0);
        chk("t6_post_ready",  64'(mdu_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
